// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter: data accesses win, and a starvation counter
// forces a pending instruction fetch ahead after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    localparam logic [1:0]       ACCESS = 2'd2;
    localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(STARVE_LIMIT);

    state_t           state;
    state_t           next;
    logic [CNT_W-1:0] scnt;
    logic             dreq;
    logic             ddone;
    logic             idone;

    // Completion needs a live request; a reset-in-progress never completes.
    assign dreq  = dREN | dWEN;
    assign ddone = (state == DGRANT) && dreq && (ramstate == ACCESS) && nRST;
    assign idone = (state == IGRANT) && iREN && (ramstate == ACCESS) && nRST;

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (iREN && (scnt == LIMIT)) next = IGRANT;
                else if (dreq)               next = DGRANT;
                else if (iREN)               next = IGRANT;
                else                         next = IDLE;
            end
            DGRANT:  if (ddone || !dreq) next = IDLE;
            IGRANT:  if (idone || !iREN) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            scnt  <= '0;
        end else begin
            state <= next;
            if (idone)
                scnt <= '0;
            else if (ddone && iREN) begin
                if (scnt != LIMIT) scnt <= scnt + 1'b1;
            end else if ((state == IDLE) && !iREN)
                scnt <= '0;
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        unique case (state)
            DGRANT: begin
                ramaddr  = daddr;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramstore = dstore;
                if (ddone) begin
                    dwait = 1'b0;
                    dload = dWEN ? 32'h0 : ramload;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (idone) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: each task drives one scenario
// and checks outputs mid-cycle against hand-computed values.
module tb_mem_arbiter;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        ramstate = FREE;
    endtask

    task automatic test_reset();
        nRST = 0; iREN = 1; dREN = 1; dWEN = 0;
        iaddr = 32'hFFFF_0000; daddr = 32'h0000_FFFF;
        dstore = 32'h1234_5678; ramload = 32'h8765_4321;
        ramstate = ACCESS;
        step(); step(); #1;
        checks++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
            $display("FAIL reset_ctl got=%b want=0011",
                     {ramREN, ramWEN, iwait, dwait});
            failures++;
        end
        checks++;
        if ({ramaddr, ramstore, iload, dload} !== 128'h0) begin
            $display("FAIL reset_data addr=%h store=%h il=%h dl=%h want 0",
                     ramaddr, ramstore, iload, dload);
            failures++;
        end
        clear_inputs();
        nRST = 1;
        step();
    endtask

    task automatic test_fetch();
        iREN = 1; iaddr = 32'h100; ramload = 32'hDEADBEEF; ramstate = FREE;
        #1;
        checks++;
        if ({ramREN, iwait} !== 2'b01) begin
            $display("FAIL fetch_idle got=%b want=01", {ramREN, iwait});
            failures++;
        end
        step(); ramstate = ACCESS; #1;
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin
            $display("FAIL fetch_grant ren=%b addr=%h want 1 100",
                     ramREN, ramaddr);
            failures++;
        end
        checks++;
        if (iwait !== 1'b0 || iload !== 32'hDEADBEEF) begin
            $display("FAIL fetch_done iwait=%b iload=%h want 0 deadbeef",
                     iwait, iload);
            failures++;
        end
        step(); clear_inputs(); #1;
        checks++;
        if ({ramREN, iwait} !== 2'b01 || iload !== 32'h0) begin
            $display("FAIL fetch_idle2 ren=%b iwait=%b iload=%h want 0 1 0",
                     ramREN, iwait, iload);
            failures++;
        end
    endtask

    task automatic test_write_beats_fetch();
        iREN = 1; iaddr = 32'h300;
        dWEN = 1; daddr = 32'h200; dstore = 32'h5A5A5A5A;
        #1;
        step(); ramstate = ACCESS; #1;
        checks++;
        if ({ramREN, ramWEN} !== 2'b01 || ramaddr !== 32'h200 ||
            ramstore !== 32'h5A5A5A5A) begin
            $display("FAIL wbf_dgrant ren=%b wen=%b addr=%h st=%h",
                     ramREN, ramWEN, ramaddr, ramstore);
            failures++;
        end
        checks++;
        if ({dwait, iwait} !== 2'b01 || dload !== 32'h0) begin
            $display("FAIL wbf_ddone dwait=%b iwait=%b dload=%h want 0 1 0",
                     dwait, iwait, dload);
            failures++;
        end
        step(); dWEN = 0; ramstate = FREE; #1;
        checks++;
        if ({ramREN, ramWEN} !== 2'b00 || ramaddr !== 32'h0) begin
            $display("FAIL wbf_bubble ren=%b wen=%b addr=%h want idle",
                     ramREN, ramWEN, ramaddr);
            failures++;
        end
        step(); ramstate = ACCESS; #1;
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h300 || iwait !== 1'b0) begin
            $display("FAIL wbf_igrant ren=%b addr=%h iwait=%b want 1 300 0",
                     ramREN, ramaddr, iwait);
            failures++;
        end
        step(); clear_inputs(); #1;
    endtask

    task automatic test_starvation();
        iREN = 1; iaddr = 32'h500;
        dREN = 1; daddr = 32'h400;
        for (int k = 0; k < 4; k++) begin
            ramstate = FREE; #1;
            checks++;
            if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin
                $display("FAIL starve_idle%0d ren=%b addr=%h want idle",
                         k, ramREN, ramaddr);
                failures++;
            end
            step(); ramstate = ACCESS; ramload = 32'hA000 + k; #1;
            checks++;
            if (ramaddr !== 32'h400 || dwait !== 1'b0 ||
                dload !== 32'hA000 + k) begin
                $display("FAIL starve_d%0d addr=%h dwait=%b dload=%h",
                         k, ramaddr, dwait, dload);
                failures++;
            end
            step();
        end
        ramstate = FREE; #1;
        step(); ramstate = ACCESS; ramload = 32'hB0B0; #1;
        checks++;
        if (ramaddr !== 32'h500 || ramREN !== 1'b1 || iwait !== 1'b0 ||
            dwait !== 1'b1 || iload !== 32'hB0B0) begin
            $display("FAIL starve_fetch addr=%h ren=%b iwait=%b dwait=%b",
                     ramaddr, ramREN, iwait, dwait);
            failures++;
        end
        step(); ramstate = FREE; #1;
        step(); ramstate = ACCESS; #1;
        checks++;
        if (ramaddr !== 32'h400 || dwait !== 1'b0) begin
            $display("FAIL starve_reset addr=%h dwait=%b want 400 0",
                     ramaddr, dwait);
            failures++;
        end
        step(); clear_inputs(); #1;
    endtask

    task automatic test_wait_states();
        logic [1:0] seq [3];
        seq[0] = BUSY; seq[1] = BUSY; seq[2] = ERROR;
        dREN = 1; daddr = 32'h600; ramload = 32'h1234_5678;
        #1;
        for (int k = 0; k < 3; k++) begin
            step(); ramstate = seq[k]; #1;
            checks++;
            if (dwait !== 1'b1 || ramREN !== 1'b1 ||
                ramaddr !== 32'h600 || dload !== 32'h0) begin
                $display("FAIL wait_hold%0d dwait=%b ren=%b addr=%h",
                         k, dwait, ramREN, ramaddr);
                failures++;
            end
        end
        step(); ramstate = ACCESS; #1;
        checks++;
        if (dwait !== 1'b0 || dload !== 32'h1234_5678) begin
            $display("FAIL wait_done dwait=%b dload=%h want 0 12345678",
                     dwait, dload);
            failures++;
        end
        step(); clear_inputs(); #1;
    endtask

    task automatic test_rw_both();
        dREN = 1; dWEN = 1; daddr = 32'h900; dstore = 32'h11;
        ramload = 32'hCAFEF00D;
        #1;
        step(); ramstate = ACCESS; #1;
        checks++;
        if ({ramREN, ramWEN, dwait} !== 3'b010 || dload !== 32'h0) begin
            $display("FAIL rw_both ren=%b wen=%b dwait=%b dload=%h",
                     ramREN, ramWEN, dwait, dload);
            failures++;
        end
        step(); clear_inputs(); #1;
    endtask

    task automatic test_abort();
        iREN = 1; iaddr = 32'h700;
        #1;
        step(); ramstate = BUSY; #1;
        checks++;
        if (ramREN !== 1'b1 || iwait !== 1'b1) begin
            $display("FAIL abort_busy ren=%b iwait=%b want 1 1",
                     ramREN, iwait);
            failures++;
        end
        step(); iREN = 0; #1;
        checks++;
        if (ramREN !== 1'b0 || iwait !== 1'b1) begin
            $display("FAIL abort_drop ren=%b iwait=%b want 0 1",
                     ramREN, iwait);
            failures++;
        end
        step(); ramstate = ACCESS; #1;
        checks++;
        if (ramREN !== 1'b0 || ramaddr !== 32'h0 || iwait !== 1'b1) begin
            $display("FAIL abort_idle ren=%b addr=%h iwait=%b want 0 0 1",
                     ramREN, ramaddr, iwait);
            failures++;
        end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid_grant();
        dREN = 1; daddr = 32'h800;
        #1;
        step(); ramstate = BUSY; #1;
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h800) begin
            $display("FAIL rmid_grant ren=%b addr=%h want 1 800",
                     ramREN, ramaddr);
            failures++;
        end
        nRST = 0; #1;
        step(); nRST = 1; ramstate = ACCESS; #1;
        checks++;
        if (ramREN !== 1'b0 || ramaddr !== 32'h0 || dwait !== 1'b1) begin
            $display("FAIL rmid_idle ren=%b addr=%h dwait=%b want 0 0 1",
                     ramREN, ramaddr, dwait);
            failures++;
        end
        step(); #1;
        checks++;
        if (ramREN !== 1'b1 || dwait !== 1'b0) begin
            $display("FAIL rmid_regrant ren=%b dwait=%b want 1 0",
                     ramREN, dwait);
            failures++;
        end
        step(); clear_inputs(); #1;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write_beats_fetch();
        test_starvation();
        test_wait_states();
        test_rw_both();
        test_abort();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
